// File: rtl/elevator_pkg.sv
// Shared types and encodings for the elevator car controller and its tick prescaler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    DOOR = 2'b11
  } elev_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // sim_state encodings; any value with bit 1 set is PAUSE
  localparam logic [1:0] SIM_STOP = 2'b00;
  localparam logic [1:0] SIM_RUN  = 2'b01;

endpackage

// File: rtl/sim_tick_gen.sv
// Simulation-speed prescaler: one sim_tick every (TICK_BASE >> sim_speed) RUN cycles.
module sim_tick_gen
  import elevator_pkg::*;
#(
  parameter int TICK_BASE = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sim_state,
  input  logic [2:0] sim_speed,
  output logic       sim_tick
);

  localparam int CW = $clog2(TICK_BASE);
  localparam int PW = CW + 1;

  logic [CW-1:0] count;
  logic [PW-1:0] period;

  assign period = PW'(TICK_BASE) >> sim_speed;

  // ">=" lets a speed increase mid-count fire at once instead of wrapping
  assign sim_tick = (sim_state == SIM_RUN) && ({1'b0, count} >= (period - PW'(1)));

  always_ff @(posedge clk) begin
    if (!rst || sim_state == SIM_STOP) begin
      count <= '0;
    end else if (sim_state == SIM_RUN) begin
      count <= sim_tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_car_controller.sv
// SCAN-scheduled single-car motion/door controller with tick-timed travel and doors.
// Optional lobby return after idling is enabled by defining ELEVATOR_IDLE_RETURN_EN.
module elevator_car_controller
  import elevator_pkg::*;
#(
  parameter int FLOORS            = 12,
  parameter int FLOOR_W           = 4,
  parameter int TICK_BASE         = 1024,
  parameter int TRAVEL_TICKS      = 4,
  parameter int DOOR_TICKS        = 3,
  parameter int IDLE_RETURN_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         sim_state,
  input  logic [2:0]         sim_speed,
  input  logic [FLOORS-1:0]  floors_requested,
  input  logic [FLOORS-1:0]  floor_destinations,
  output logic [FLOOR_W-1:0] car_floor,
  output logic [1:0]         elevator_state,
  output logic [FLOORS-1:0]  floor_served,
  output logic               sim_tick
);

  localparam int TMAX_TD = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TMAX    = (TMAX_TD > IDLE_RETURN_TICKS) ? TMAX_TD : IDLE_RETURN_TICKS;
  localparam int TW      = $clog2(TMAX + 1);

  elev_state_t        state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [TW-1:0]      timer_q, timer_d;
  dir_t               dir_q, dir_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOORS-1:0]  floor_oh;
`ifdef ELEVATOR_IDLE_RETURN_EN
  logic               ret_q, ret_d;
`endif

  // One SCAN decision used from IDLE, at door close and on arrival at a floor
  function automatic elev_state_t eval_next(input logic [FLOORS-1:0] p,
                                            input logic [FLOOR_W-1:0] f,
                                            input dir_t d);
    logic here, above, below;
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i]) begin
        if (i == int'(f))     here  = 1'b1;
        else if (i > int'(f)) above = 1'b1;
        else                  below = 1'b1;
      end
    end
    if (here)           return DOOR;
    if (above && below) return (d == DIR_UP) ? UP : DOWN;
    if (above)          return UP;
    if (below)          return DOWN;
    return IDLE;
  endfunction

  sim_tick_gen #(
    .TICK_BASE(TICK_BASE)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .sim_state(sim_state),
    .sim_speed(sim_speed),
    .sim_tick (sim_tick)
  );

  assign floor_oh       = FLOORS'(1) << floor_q;
  assign car_floor      = floor_q;
  assign elevator_state = state_q;
  assign floor_served   = (state_q == DOOR) ? floor_oh : '0;

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
`ifdef ELEVATOR_IDLE_RETURN_EN
    ret_d     = ret_q;
`endif
    // Serving the current floor wins over a request arriving in the same cycle
    pending_d = pending_q | floors_requested | floor_destinations;
    if (state_q == DOOR) pending_d = pending_d & ~floor_oh;

    if (sim_state == SIM_RUN) begin
      case (state_q)
        IDLE: begin
          state_d = eval_next(pending_q, floor_q, dir_q);
          timer_d = '0;
`ifdef ELEVATOR_IDLE_RETURN_EN
          if (state_d == IDLE && floor_q != '0) begin
            timer_d = timer_q;
            if (sim_tick) begin
              if (timer_q == TW'(IDLE_RETURN_TICKS - 1)) begin
                state_d = DOWN;
                ret_d   = 1'b1;
                timer_d = '0;
              end else begin
                timer_d = timer_q + 1'b1;
              end
            end
          end
`endif
        end
        UP, DOWN: begin
          if (sim_tick) begin
            if (timer_q == TW'(TRAVEL_TICKS - 1)) begin
              dir_d   = (state_q == UP) ? DIR_UP : DIR_DOWN;
              floor_d = (state_q == UP) ? floor_q + 1'b1 : floor_q - 1'b1;
              timer_d = '0;
              state_d = eval_next(pending_q, floor_d, dir_d);
`ifdef ELEVATOR_IDLE_RETURN_EN
              // A lobby return keeps descending only while nothing is pending
              if (ret_q && state_d == IDLE && floor_d != '0) state_d = DOWN;
              else                                           ret_d   = 1'b0;
`endif
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        DOOR: begin
          if (sim_tick) begin
            if (timer_q == TW'(DOOR_TICKS - 1)) begin
              timer_d = '0;
              state_d = eval_next(pending_q & ~floor_oh, floor_q, dir_q);
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || sim_state == SIM_STOP) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      timer_q   <= '0;
      dir_q     <= DIR_UP;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      timer_q   <= timer_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
    end
  end

`ifdef ELEVATOR_IDLE_RETURN_EN
  always_ff @(posedge clk) begin
    if (!rst || sim_state == SIM_STOP) ret_q <= 1'b0;
    else                               ret_q <= ret_d;
  end
`endif

endmodule

// File: tb/tb_elevator_car_controller.sv
// Directed and random checks of elevator_car_controller against a floor-level reference model.
module tb_elevator_car_controller;

  localparam int FLOORS  = 12;
  localparam int TB_BASE = 1024;
  localparam int TRAVEL  = 4;
  localparam int DOORT   = 3;
  localparam int IRT     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sim_state;
  logic [2:0]  sim_speed;
  logic [11:0] floors_requested;
  logic [11:0] floor_destinations;
  logic [3:0]  car_floor;
  logic [1:0]  elevator_state;
  logic [11:0] floor_served;
  logic        sim_tick;

  int checks = 0;
  int fails  = 0;

  // Reference model: mode 0 idle, 1 up, 2 down, 3 door; dir +1/-1
  bit [11:0] m_pend;
  int        m_floor, m_mode, m_timer, m_dir, m_cnt;
  bit        m_ret;

  always #5 clk = ~clk;

  elevator_car_controller dut (
    .clk               (clk),
    .rst               (rst),
    .sim_state         (sim_state),
    .sim_speed         (sim_speed),
    .floors_requested  (floors_requested),
    .floor_destinations(floor_destinations),
    .car_floor         (car_floor),
    .elevator_state    (elevator_state),
    .floor_served      (floor_served),
    .sim_tick          (sim_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SCAN choice from a floor: serve here, else keep preferred direction if both sides wait
  function automatic int choose(input bit [11:0] p, input int f, input int d);
    int above = 0;
    int below = 0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && i > f) above++;
      if (p[i] && i < f) below++;
    end
    if (p[f]) return 3;
    if (above > 0 && below > 0) return (d > 0) ? 1 : 2;
    if (above > 0) return 1;
    if (below > 0) return 2;
    return 0;
  endfunction

  task automatic checkOutput();
    bit [11:0] exp_served;
    bit        exp_tick;
    exp_served = (m_mode == 3) ? (12'b1 << m_floor) : 12'b0;
    exp_tick   = (sim_state == 2'b01) && (m_cnt >= (TB_BASE >> sim_speed) - 1);
    check("car_floor", 32'(car_floor), 32'(m_floor));
    check("elevator_state", 32'(elevator_state), 32'(m_mode));
    check("floor_served", 32'(floor_served), 32'(exp_served));
    check("sim_tick", 32'(sim_tick), 32'(exp_tick));
  endtask

  // Advance the model by one clock using the inputs currently driven, then compare
  task automatic applyStimulus();
    int        period;
    int        nm;
    bit        tick;
    bit [11:0] np;
    bit [11:0] tmp;
    if (!rst || sim_state == 2'b00) begin
      m_pend = '0; m_floor = 0; m_mode = 0; m_timer = 0; m_dir = 1; m_cnt = 0; m_ret = 0;
    end else begin
      np = m_pend | floors_requested | floor_destinations;
      if (m_mode == 3) np[m_floor] = 1'b0;
      if (sim_state == 2'b01) begin
        period = TB_BASE >> sim_speed;
        tick   = (m_cnt >= period - 1);
        m_cnt  = tick ? 0 : m_cnt + 1;
        case (m_mode)
          0: begin
            nm = choose(m_pend, m_floor, m_dir);
`ifdef ELEVATOR_IDLE_RETURN_EN
            if (nm == 0 && m_floor != 0) begin
              if (tick) m_timer++;
              if (m_timer == IRT) begin
                nm = 2; m_ret = 1; m_timer = 0;
              end
            end else begin
              m_timer = 0;
            end
`else
            m_timer = 0;
`endif
            m_mode = nm;
          end
          1, 2: if (tick) begin
            m_timer++;
            if (m_timer == TRAVEL) begin
              m_timer = 0;
              m_dir   = (m_mode == 1) ? 1 : -1;
              m_floor = m_floor + m_dir;
              m_mode  = choose(m_pend, m_floor, m_dir);
`ifdef ELEVATOR_IDLE_RETURN_EN
              if (m_ret && m_mode == 0 && m_floor != 0) m_mode = 2;
              else m_ret = 0;
`endif
            end
          end
          default: if (tick) begin
            m_timer++;
            if (m_timer == DOORT) begin
              m_timer = 0;
              tmp = m_pend;
              tmp[m_floor] = 1'b0;
              m_mode = choose(tmp, m_floor, m_dir);
            end
          end
        endcase
      end
      m_pend = np;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic waitState(input logic [1:0] s, input bit equal, input int limit, input string tag);
    int n = 0;
    while (((elevator_state == s) != equal) && n < limit) begin
      applyStimulus();
      n++;
    end
    check(tag, 32'(n < limit), 32'd1);
  endtask

  initial begin
    int n;
    int f;
    rst = 1'b0; sim_state = 2'b00; sim_speed = 3'd7;
    floors_requested = '0; floor_destinations = '0;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    check("reset_floor", 32'(car_floor), 32'd0);
    check("reset_state", 32'(elevator_state), 32'd0);

    // Hall call at floor 3, held until served
    $display("[TB] hall call to floor 3");
    sim_state = 2'b01;
    floors_requested = 12'h008;
    n = 0;
    while (elevator_state != 2'b11 && n < 400) begin
      applyStimulus();
      n++;
    end
    floors_requested = '0;
    check("arrive3_cycles", 32'(n), 32'd96);
    check("arrive3_floor", 32'(car_floor), 32'd3);
    check("arrive3_served", 32'(floor_served), 32'h008);
    n = 0;
    while (elevator_state == 2'b11 && n < 100) begin
      applyStimulus();
      n++;
    end
    check("door3_cycles", 32'(n), 32'd24);
    check("after_door3_idle", 32'(elevator_state), 32'd0);

    // Car call at the floor the car is idling on opens the door next cycle
    $display("[TB] car call at current floor");
    floor_destinations = 12'h010;
    applyStimulus();
    floor_destinations = '0;
    waitState(2'b11, 1'b1, 300, "reach4_timeout");
    waitState(2'b11, 1'b0, 100, "door4_timeout");
    floor_destinations = 12'h010;
    applyStimulus();
    floor_destinations = '0;
    applyStimulus();
    check("same_floor_state", 32'(elevator_state), 32'd3);
    check("same_floor_floor", 32'(car_floor), 32'd4);
    check("same_floor_served", 32'(floor_served), 32'h010);
    waitState(2'b11, 1'b0, 100, "door4b_timeout");

    // SCAN: moving up past 5 with {2,8} pending serves 8 before 2
    $display("[TB] scan ordering");
    floors_requested = 12'h100;
    applyStimulus();
    floors_requested = '0;
    n = 0;
    while (car_floor != 4'd5 && n < 300) begin
      applyStimulus();
      n++;
    end
    check("reach5_timeout", 32'(n < 300), 32'd1);
    check("moving_up_at5", 32'(elevator_state), 32'd1);
    floors_requested = 12'h004;
    applyStimulus();
    floors_requested = '0;
    waitState(2'b11, 1'b1, 600, "door8_timeout");
    check("first_stop", 32'(car_floor), 32'd8);
    waitState(2'b11, 1'b0, 100, "door8_close_timeout");
    waitState(2'b11, 1'b1, 1200, "door2_timeout");
    check("second_stop", 32'(car_floor), 32'd2);
    waitState(2'b11, 1'b0, 100, "door2_close_timeout");

    // PAUSE mid-travel freezes everything
    $display("[TB] pause mid-travel");
    floors_requested = 12'h400;
    applyStimulus();
    floors_requested = '0;
    waitState(2'b01, 1'b1, 50, "start_up_timeout");
    for (int i = 0; i < 10; i++) applyStimulus();
    f = int'(car_floor);
    sim_state = 2'b10;
    for (int i = 0; i < 100; i++) applyStimulus();
    check("pause_floor", 32'(car_floor), 32'(f));
    check("pause_state", 32'(elevator_state), 32'd1);
    sim_state = 2'b01;
    waitState(2'b11, 1'b1, 2000, "door10_timeout");
    check("after_pause_stop", 32'(car_floor), 32'd10);
    waitState(2'b11, 1'b0, 100, "door10_close_timeout");

    // Reset held low for two cycles while moving
    $display("[TB] reset mid-run");
    floors_requested = 12'h001;
    applyStimulus();
    floors_requested = '0;
    for (int i = 0; i < 40; i++) applyStimulus();
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    check("midreset_floor", 32'(car_floor), 32'd0);
    check("midreset_state", 32'(elevator_state), 32'd0);
    check("midreset_served", 32'(floor_served), 32'd0);
    check("midreset_tick", 32'(sim_tick), 32'd0);
    rst = 1'b1;
    applyStimulus();

`ifdef ELEVATOR_IDLE_RETURN_EN
    $display("[TB] idle return to lobby");
    floor_destinations = 12'h040;
    applyStimulus();
    floor_destinations = '0;
    waitState(2'b11, 1'b1, 600, "door6_timeout");
    waitState(2'b11, 1'b0, 100, "door6_close_timeout");
    waitState(2'b10, 1'b1, 200, "return_start_timeout");
    check("return_from", 32'(car_floor), 32'd6);
    waitState(2'b00, 1'b1, 1000, "return_end_timeout");
    check("return_floor", 32'(car_floor), 32'd0);
`endif

    // Random segments of run/pause/stop, speed changes and sparse requests
    $display("[TB] random traffic");
    for (int seg = 0; seg < 50; seg++) begin
      n = $urandom_range(0, 99);
      sim_state = (n < 3) ? 2'b00 : (n < 12) ? 2'(2 + $urandom_range(0, 1)) : 2'b01;
      sim_speed = 3'($urandom_range(5, 7));
      for (int c = 0, len = $urandom_range(20, 150); c < len; c++) begin
        rst = ($urandom_range(0, 499) != 0);
        floors_requested   = ($urandom_range(0, 15) == 0) ? 12'(1 << $urandom_range(0, 11)) : 12'h000;
        floor_destinations = ($urandom_range(0, 15) == 0) ? 12'(1 << $urandom_range(0, 11)) : 12'h000;
        applyStimulus();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
